// File: rtl/psw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psw_pkg
//  Description : Shared types and default timing constants for the push-switch
//                conditioning blocks (debouncer FSM state encoding, 50 MHz
//                board defaults, counter width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package psw_pkg;

    // Debouncer FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } psw_state_t;

    // Board defaults for a 50 MHz clock
    localparam int c_clk_hz               = 50_000_000;
    localparam int c_debounce_cycles_def  = 500_000;     // 10 ms
    localparam int c_repeat_delay_def     = 25_000_000;  // 500 ms
    localparam int c_repeat_period_def    = 10_000_000;  // 200 ms

    // Bits needed to hold values 0..max_value, never less than one bit
    function automatic int psw_cnt_width(input int max_value);
        int w;
        if (max_value < 1) begin
            w = 1;
        end else begin
            w = $clog2(max_value + 1);
        end
        return w;
    endfunction

endpackage : psw_pkg
`default_nettype wire

// File: rtl/psw_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : psw_sync2
//  Description : Two-flop synchroniser for an asynchronous single-bit board
//                input. Both stages clear on synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module psw_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Two-stage metastability filter; first stage may go metastable, second is clean
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule : psw_sync2
`default_nettype wire

// File: rtl/psw_debounce_one.sv
`default_nettype none
// ============================================================================
//  Module      : psw_debounce_one
//  Description : Push-switch conditioner. Synchronises the raw switch, rejects
//                bounce with a stable-time counter and emits one-cycle pulses
//                on each accepted press (PRESS_ONE) and release (RELEASE_ONE),
//                plus the debounced level (LEVEL). All outputs registered.
//                Optional auto-repeat of PRESS_ONE while held is enabled by
//                defining the macro PSW_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module psw_debounce_one
    import psw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_def,
    parameter int REPEAT_DELAY    = c_repeat_delay_def,
    parameter int REPEAT_PERIOD   = c_repeat_period_def
) (
    input  logic CLK,
    input  logic R,
    input  logic PSW,
    output logic LEVEL,
    output logic PRESS_ONE,
    output logic RELEASE_ONE
);

    localparam int             c_cnt_w   = psw_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    // ------------------------------------------------------------------------
    // Synchronised switch
    // ------------------------------------------------------------------------
    logic w_s2;

    psw_sync2 u_sync (
        .clk (CLK),
        .rst (R),
        .i_d (PSW),
        .o_q (w_s2)
    );

    // ------------------------------------------------------------------------
    // FSM and stable-time counter
    // ------------------------------------------------------------------------
    psw_state_t          r_state;
    psw_state_t          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic                r_level;
    logic                w_level_nxt;
    logic                r_press;
    logic                w_press_nxt;
    logic                r_release;
    logic                w_release_nxt;
    logic                w_accept_press;
    logic                w_rep_hit;

    // Next-state, counter and pulse decode; every exit from a wait state
    // either clears the counter or leaves it unused, so it never wraps
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_accept_press = 1'b0;
        w_release_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_s2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = c_cnt_one;
                end
            end

            PRESS_WAIT: begin
                if (!w_s2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt    = PRESSED;
                    w_cnt_nxt      = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            PRESSED: begin
                w_cnt_nxt = '0;
                if (!w_s2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = c_cnt_one;
                end
            end

            RELEASE_WAIT: begin
                if (w_s2) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Level reflects the accepted state, so it flips with the pulse
        w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
        w_press_nxt = w_accept_press || w_rep_hit;
    end

    // State, counter and registered outputs
    always_ff @(posedge CLK) begin
        if (R) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

`ifdef PSW_AUTOREPEAT_EN
    // ------------------------------------------------------------------------
    // Auto-repeat: first repeat REPEAT_DELAY cycles after the accepted press
    // pulse, then every REPEAT_PERIOD cycles while the switch stays pressed.
    // ------------------------------------------------------------------------
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rep_w   = psw_cnt_width(c_rep_max - 1);
    localparam logic [c_rep_w-1:0] c_rep_first = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_rep_next  = c_rep_w'(REPEAT_PERIOD - 1);
    localparam logic [c_rep_w-1:0] c_rep_one   = c_rep_w'(1);

    logic [c_rep_w-1:0] r_rcnt;
    logic [c_rep_w-1:0] w_rcnt_nxt;
    logic               r_rep_first;
    logic               w_rep_first_nxt;
    logic [c_rep_w-1:0] w_rep_target;

    // Repeat due only while staying in PRESSED; a release that starts in the
    // same cycle suppresses it
    always_comb begin
        w_rep_target    = r_rep_first ? c_rep_first : c_rep_next;
        w_rep_hit       = (r_state == PRESSED) && w_s2 && (r_rcnt == w_rep_target);
        w_rcnt_nxt      = r_rcnt;
        w_rep_first_nxt = r_rep_first;

        if (w_state_nxt != PRESSED) begin
            w_rcnt_nxt = '0;
        end else if (r_state != PRESSED) begin
            w_rcnt_nxt = '0;
            if (r_state == PRESS_WAIT) begin
                w_rep_first_nxt = 1'b1;
            end
        end else if (w_rep_hit) begin
            w_rcnt_nxt      = '0;
            w_rep_first_nxt = 1'b0;
        end else begin
            w_rcnt_nxt = r_rcnt + c_rep_one;
        end
    end

    // Repeat counter and first-interval flag
    always_ff @(posedge CLK) begin
        if (R) begin
            r_rcnt      <= '0;
            r_rep_first <= 1'b1;
        end else begin
            r_rcnt      <= w_rcnt_nxt;
            r_rep_first <= w_rep_first_nxt;
        end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    assign LEVEL       = r_level;
    assign PRESS_ONE   = r_press;
    assign RELEASE_ONE = r_release;

endmodule : psw_debounce_one
`default_nettype wire
